// File: rtl/ft245_tx_arbiter_pkg.sv
// Shared types and constants for the FT245 TX stream arbiter.
// Channel index width is capped at 4 bits so it fits the header's low nibble.
package ft245_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      LEN  = 2'd2,
      DATA = 2'd3
   } arb_state_t;

   localparam logic [3:0] HDR_TAG_DEF = 4'hA;
   localparam int         MAX_CH      = 16;

endpackage

// File: rtl/ft245_tx_arbiter_rr_arbiter.sv
// Round-robin pick: first requester strictly after ptr, wrapping; purely combinational.
// Latency 0; no backpressure, the parent samples gnt/gnt_idx when it decides.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic [W-1:0] cand;
   logic         found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      // Offsets start at 1 so the last-granted channel is considered last.
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      if (found) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// Muxes NUM_CH burst requesters onto one byte stream as {tag|ch, len, payload...} frames.
// One-cycle grant decision, then header bytes registered; payload passes combinationally, tx_ready stalls all.
module ft245_tx_arbiter
   import ft245_arb_pkg::*;
#(
   parameter int         NUM_CH  = 4,
   parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     ch_req,
   input  logic [NUM_CH*8-1:0]   ch_len,
   input  logic [NUM_CH*8-1:0]   ch_data,
   input  logic [NUM_CH-1:0]     ch_valid,
   output logic [NUM_CH-1:0]     ch_ready,
   output logic [NUM_CH-1:0]     ch_grant,
   output logic [NUM_CH-1:0]     ch_done,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy
);

   localparam int W = $clog2(NUM_CH);

   arb_state_t        state;
   logic [W-1:0]      cur;
   logic [W-1:0]      ptr;
   logic [W-1:0]      gnt_idx;
   logic [NUM_CH-1:0] gnt;
   logic [7:0]        len_q;
   logic [7:0]        cnt;
   logic [7:0]        hdr_dat;
   logic              hdr_vld;
   logic              xfer;

   rr_arbiter #(
      .N (NUM_CH),
      .W (W)
   ) u_rr (
      .req     (ch_req),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Header/length come from registers; payload is a straight pass-through of the owner.
   always_comb begin
      tx_valid = hdr_vld;
      tx_data  = hdr_dat;
      ch_ready = '0;
      if (state == DATA) begin
         tx_valid      = ch_valid[cur];
         tx_data       = ch_data[int'(cur)*8 +: 8];
         ch_ready[cur] = tx_ready;
      end
   end

   assign xfer = tx_valid && tx_ready;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cur      <= '0;
         ptr      <= W'(NUM_CH - 1);
         len_q    <= '0;
         cnt      <= '0;
         hdr_dat  <= '0;
         hdr_vld  <= 1'b0;
         ch_grant <= '0;
         ch_done  <= '0;
      end else begin
         ch_done <= '0;
         case (state)
            IDLE: begin
               if (|ch_req) begin
                  state    <= HDR;
                  cur      <= gnt_idx;
                  ptr      <= gnt_idx;
                  ch_grant <= gnt;
                  len_q    <= ch_len[int'(gnt_idx)*8 +: 8];
                  hdr_vld  <= 1'b1;
                  hdr_dat  <= {HDR_TAG, 4'(gnt_idx)};
               end
            end
            HDR: begin
               if (xfer) begin
                  state   <= LEN;
                  hdr_dat <= len_q;
               end
            end
            LEN: begin
               if (xfer) begin
                  hdr_vld <= 1'b0;
                  hdr_dat <= '0;
                  cnt     <= '0;
                  if (len_q == 8'd0) begin
                     ch_done  <= ch_grant;
                     ch_grant <= '0;
                     state    <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  cnt <= cnt + 8'd1;
                  if (cnt == len_q - 8'd1) begin
                     ch_done  <= ch_grant;
                     ch_grant <= '0;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ft245_tx_arbiter.md
Name: ft245_tx_arbiter

Overview:
- Shares the single TX simple-interface stream of the FT245 FIFO block between NUM_CH independent requesters.
- Each requester asks for a burst of known length.
- The arbiter grants round-robin and emits a 2-byte frame header (tag/channel byte, length byte), then forwards exactly that many payload bytes from the granted channel.
- Sits between the USB-bound data producers (samplers, status/register readback) and the tx_data_si/tx_valid_si/tx_ready_si port of the FT245 block.

Parameters:
- NUM_CH, 4, number of requesters; legal range 2..16.
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- clk  in  1  system clock (the FT245 block's clock).
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ch_req  in  NUM_CH  per-channel burst request, level.
- ch_len  in  NUM_CH*8  per-channel burst length; channel i is at [8i+7:8i]; sampled at grant.
- ch_data  in  NUM_CH*8  per-channel payload byte, same packing.
- ch_valid  in  NUM_CH  payload byte valid.
- ch_ready  out  NUM_CH  payload byte accepted.
- ch_grant  out  NUM_CH  one-hot; the granted channel is high from grant until frame end.
- ch_done  out  NUM_CH  one-cycle pulse on the cycle the granted channel's frame completes.
- tx_data  out  8  stream byte to the FT245 block's tx_data_si.
- tx_valid  out  1  to tx_valid_si.
- tx_ready  in  1  from tx_ready_si.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ch_grant=0, ch_done=0, ch_ready=0, tx_valid=0, tx_data=0, busy=0, rr pointer=NUM_CH-1, len_q=0, cnt=0.
- Transfer rule: a byte moves on a cycle where tx_valid && tx_ready.
- In HDR and LEN, tx_valid/tx_data are registered and stay stable until accepted.
- In DATA the path is combinational:
  - tx_valid = ch_valid[cur]
  - tx_data = ch_data[cur]
  - ch_ready[cur] = tx_ready
  - all other ch_ready are 0.
- State machine:
  - IDLE: if any ch_req, pick the first requesting channel after the rr pointer (wrapping). Set cur, ch_grant[cur]=1, len_q=ch_len[cur], rr pointer=cur. Next state is HDR. The decision takes one cycle.
  - HDR: tx_data={HDR_TAG, cur[3:0]}, tx_valid=1. On transfer go to LEN.
  - LEN: tx_data=len_q. On transfer: if len_q==0, pulse ch_done[cur] and go to IDLE; else cnt=0 and go to DATA.
  - DATA: cnt increments on each transfer. On the transfer where cnt==len_q-1: pulse ch_done[cur], drop ch_grant, go to IDLE.
- Frame length: len range 0..255; len 0 gives a header-only frame (2 bytes).
- Back-to-back frames: exactly one idle bubble cycle (IDLE) between frames.
- Frame integrity:
  - No preemption; the granted channel owns the stream until len_q bytes have been sent.
  - Deasserting ch_req mid-frame is ignored.
  - A channel stalling ch_valid stalls the stream indefinitely; there is no timeout.
- Simultaneous requests: round-robin. The channel granted last has lowest priority next time. A lone requester is re-granted each frame.
- ch_len changes after grant have no effect on the current frame.
- Reset mid-frame: the frame is abandoned immediately and tx_valid drops asynchronously. The downstream FT245 block must be reset by the same rst.

Decomposition:
- Package ft245_arb_pkg holds:
  - state enum IDLE/HDR/LEN/DATA
  - HDR_TAG default
  - max channel constant 16
- Sub-module rr_arbiter #(N):
  - inputs req[N], ptr
  - outputs gnt one-hot and gnt_idx
  - combinational; the pointer register lives in the parent.

Test Plan:
- Single channel: ch_req[1]=1, len=3, data 11,22,33, tx_ready=1 -> stream A1,03,11,22,33; ch_done[1] pulses once; busy low 1 cycle later.
- Zero length: ch_req[2], len=0 -> stream A2,00; no ch_ready[2] asserted; ch_done[2] pulses after the LEN byte.
- Round-robin: all four requesting, each len=1 -> frame order ch0,ch1,ch2,ch3,ch0; exactly one bubble cycle between frames.
- Backpressure: tx_ready toggling 1010 and ch_valid gapped -> tx_data stable whenever tx_valid && !tx_ready; byte count exactly equals len; no duplicate or lost bytes.
- Mid-frame request drop and len change: ch_req[0] dropped and ch_len[0] changed after HDR -> frame still carries the original len bytes.
- Async reset during DATA, after 2 of 5 bytes -> tx_valid, ch_grant and busy are 0 without a clock edge; after release, the next request restarts at HDR with rr pointer = NUM_CH-1 (ch0 wins a tie).
